// File: rtl/dvp_pkg.sv
// Shared definitions for the disparity-pipeline DMA blocks: FSM encodings and AXI constants.
package dvp_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_AW   = 3'd2;
  localparam logic [2:0] ST_W    = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;

  localparam logic [3:0] AXI_WSTRB_ALL = 4'hF;
endpackage

// File: rtl/axi_wr_dma_if.sv
// AXI4 write-channel bundle (AW, W, B) between the write DMA master and the memory slave.
interface axi_wr_dma_if;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awlen, awvalid, wdata, wstrb, wvalid, wlast, bready,
    input  awready, wready, bvalid
  );

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wstrb, wvalid, wlast, bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/dvp_sfifo.sv
// Single-clock FIFO with occupancy count; head word is presented combinationally on rd_data.
module dvp_sfifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/axi_wr_dma.sv
// Write-side AXI master: buffers a 32-bit word stream and writes it to memory as INCR bursts.
//
// state | meaning
// IDLE  | no job; waiting for start
// WAIT  | job active; waiting until the FIFO holds a whole burst
// AW    | address phase, awvalid held until awready
// W     | data phase, one beat per wready, wlast on the final beat
// B     | waiting for the write response; advances address/remaining
module axi_wr_dma
  import dvp_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 24
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  axi_wr_dma_if.master      axi
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]       state;
  logic [31:0]      addr;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] in_left;
  logic [CNT_W-1:0] beats;
  logic [CNT_W-1:0] beats_q;
  logic [7:0]       beat_cnt;
  logic [FCW-1:0]   fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign busy        = (state != ST_IDLE);
  assign s_ready     = busy & ~fifo_full & (in_left != '0);
  assign push        = s_valid & s_ready;
  assign axi.awvalid = (state == ST_AW);
  assign axi.wvalid  = (state == ST_W) & ~fifo_empty;
  assign axi.wlast   = axi.wvalid & (beat_cnt == axi.awlen);
  assign axi.bready  = (state == ST_B);
  assign axi.wstrb   = AXI_WSTRB_ALL;
  assign pop         = axi.wvalid & axi.wready;
  assign beats       = (rem > CNT_W'(BURST_LEN)) ? CNT_W'(BURST_LEN) : rem;

  dvp_sfifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (axi_aclk),
    .rst     (axi_areset),
    .push    (push),
    .wr_data (s_data),
    .pop     (pop),
    .rd_data (axi.wdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state      <= ST_IDLE;
      addr       <= '0;
      rem        <= '0;
      in_left    <= '0;
      beats_q    <= '0;
      beat_cnt   <= '0;
      done       <= 1'b0;
      axi.awaddr <= '0;
      axi.awlen  <= '0;
    end else begin
      done <= 1'b0;
      if (push) in_left <= in_left - CNT_W'(1);
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr    <= base_addr;
            rem     <= num_words;
            in_left <= num_words;
            if (num_words != '0) state <= ST_WAIT;
            else                 done  <= 1'b1;
          end
        end
        // A burst is only launched once all of its data is buffered, so W never starves.
        ST_WAIT: begin
          if (CNT_W'(fifo_count) >= beats) begin
            axi.awaddr <= addr;
            axi.awlen  <= 8'(beats - CNT_W'(1));
            beats_q    <= beats;
            state      <= ST_AW;
          end
        end
        ST_AW: begin
          if (axi.awready) begin
            beat_cnt <= '0;
            state    <= ST_W;
          end
        end
        ST_W: begin
          if (pop) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (axi.wlast) state <= ST_B;
          end
        end
        ST_B: begin
          if (axi.bvalid) begin
            addr <= addr + (32'(beats_q) << 2);
            rem  <= rem - beats_q;
            if (rem == beats_q) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_wr_dma.sv
// Directed bench for axi_wr_dma: stream source, AXI slave memory model and protocol monitor.
module tb_axi_wr_dma;
  logic        axi_aclk = 1'b0;
  logic        axi_areset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [23:0] num_words = '0;
  logic        busy;
  logic        done;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  axi_wr_dma_if axi ();

  axi_wr_dma dut (
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .axi        (axi)
  );

  always #5 axi_aclk = ~axi_aclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit          src_rand = 0;
  bit          w_rand = 0;
  bit          aw_hold = 0;
  int          src_idx = 0;
  logic [31:0] data_base = '0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q [$];
  int          w_cnt = 0, b_cnt = 0, done_cnt = 0, b_cyc = 0, done_cyc = 0;
  logic [31:0] cur_addr = '0;
  logic [7:0]  cur_len = '0;
  int          wbeat = 0;
  bit          pend_b = 0, in_burst = 0, w_stall = 0, aw_stall = 0;
  logic [31:0] p_wdata = '0, p_awaddr = '0;
  logic [7:0]  p_awlen = '0;
  logic        p_wlast = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Stream source: word value = data_base + index within the job.
  initial begin : source
    bit xfer;
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(negedge axi_aclk);
      xfer = s_valid && s_ready && !axi_areset;
      @(posedge axi_aclk);
      #1;
      if (xfer) src_idx++;
      s_valid = src_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_data  = data_base + 32'(src_idx);
    end
  end

  // AXI slave memory plus protocol monitor, sampled mid-cycle.
  initial begin : slave
    bit aw_hs, w_hs, b_hs;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    forever begin
      @(negedge axi_aclk);
      cyc++;
      if (axi_areset) begin
        pend_b = 0; in_burst = 0; wbeat = 0; w_stall = 0; aw_stall = 0;
      end else begin
        aw_hs = axi.awvalid && axi.awready;
        w_hs  = axi.wvalid && axi.wready;
        b_hs  = axi.bvalid && axi.bready;
        if (aw_stall) begin
          chk("aw_hold_valid", 32'(axi.awvalid), 1);
          chk("aw_hold_addr", axi.awaddr, p_awaddr);
          chk("aw_hold_len", 32'(axi.awlen), 32'(p_awlen));
        end
        if (w_stall) begin
          chk("w_hold_valid", 32'(axi.wvalid), 1);
          chk("w_hold_data", axi.wdata, p_wdata);
          chk("w_hold_last", 32'(axi.wlast), 32'(p_wlast));
        end else if (in_burst) begin
          chk("w_no_gap", 32'(axi.wvalid), 1);
        end
        if (aw_hs) begin
          aw_addr_q.push_back(axi.awaddr);
          aw_len_q.push_back(axi.awlen);
          cur_addr = axi.awaddr;
          cur_len  = axi.awlen;
          wbeat    = 0;
        end
        if (w_hs) begin
          chk("wlast_pos", 32'(axi.wlast), 32'(wbeat == int'(cur_len)));
          mem[cur_addr + 32'(wbeat) * 4] = axi.wdata;
          w_cnt++;
          wbeat++;
          in_burst = !axi.wlast;
          if (axi.wlast) pend_b = 1;
        end
        if (b_hs) begin
          b_cnt++;
          b_cyc  = cyc;
          pend_b = 0;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        aw_stall = axi.awvalid && !axi.awready;
        p_awaddr = axi.awaddr;
        p_awlen  = axi.awlen;
        w_stall  = axi.wvalid && !axi.wready;
        p_wdata  = axi.wdata;
        p_wlast  = axi.wlast;
      end
      @(posedge axi_aclk);
      #1;
      axi.awready = !aw_hold;
      axi.wready  = w_rand ? ($urandom_range(0, 9) >= 3) : 1'b1;
      axi.bvalid  = pend_b;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    aw_addr_q.delete();
    aw_len_q.delete();
    mem.delete();
    w_cnt = 0; b_cnt = 0; done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [23:0] n);
    @(posedge axi_aclk);
    #1;
    base_addr = b; num_words = n; start = 1'b1;
    @(posedge axi_aclk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < bound) begin
      @(posedge axi_aclk);
      #2;
      n++;
    end
    chk(tag, done_cnt, d0 + 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_awvalid"}, 32'(axi.awvalid), 0);
    chk({tag, "_wvalid"}, 32'(axi.wvalid), 0);
    chk({tag, "_wlast"}, 32'(axi.wlast), 0);
    chk({tag, "_bready"}, 32'(axi.bready), 0);
    chk({tag, "_awaddr"}, axi.awaddr, 0);
    chk({tag, "_awlen"}, 32'(axi.awlen), 0);
  endtask

  // Bursts of 16 from base, last one short; memory holds data_base+0..num-1.
  task automatic check_job(input string tag, input logic [31:0] base, input int num);
    int nb = (num + 15) / 16;
    logic [31:0] a;
    chk({tag, "_aw_cnt"}, aw_addr_q.size(), nb);
    chk({tag, "_b_cnt"}, b_cnt, nb);
    chk({tag, "_w_cnt"}, w_cnt, num);
    for (int i = 0; i < nb && i < aw_addr_q.size(); i++) begin
      chk({tag, "_awaddr"}, aw_addr_q[i], base + 32'(i * 64));
      chk({tag, "_awlen"}, 32'(aw_len_q[i]), (num - 16 * i >= 16) ? 15 : num - 16 * i - 1);
    end
    for (int i = 0; i < num; i++) begin
      a = base + 32'(i * 4);
      chk({tag, "_mem"}, mem.exists(a) ? mem[a] : 32'hDEAD_BEEF, data_base + 32'(i));
    end
  endtask

  initial begin : main
    int n;
    repeat (3) @(posedge axi_aclk);
    #1;
    check_outputs_zero("reset");
    axi_areset = 1'b0;

    // 1: single full burst
    clear_logs(); data_base = 32'h0000_1000; src_idx = 0;
    pulse_start(32'h0040_0000, 24'd16);
    wait_done("t1_done", 200);
    chk("t1_aw_cnt", aw_addr_q.size(), 1);
    if (aw_addr_q.size() > 0) begin
      chk("t1_awaddr", aw_addr_q[0], 32'h0040_0000);
      chk("t1_awlen", 32'(aw_len_q[0]), 15);
    end
    chk("t1_done_lat", done_cyc, b_cyc + 1);
    check_job("t1", 32'h0040_0000, 16);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_done_pulse", 32'(done), 0);

    // 2: 37 words -> 16,16,5
    clear_logs(); data_base = 32'h0000_2000; src_idx = 0;
    pulse_start(32'h0040_0000, 24'd37);
    wait_done("t2_done", 400);
    chk("t2_aw_cnt", aw_addr_q.size(), 3);
    if (aw_addr_q.size() == 3) begin
      chk("t2_awaddr2", aw_addr_q[1], 32'h0040_0040);
      chk("t2_awaddr3", aw_addr_q[2], 32'h0040_0080);
      chk("t2_awlen3", 32'(aw_len_q[2]), 4);
    end
    check_job("t2", 32'h0040_0000, 37);

    // 3: random source validity and write backpressure
    clear_logs(); data_base = 32'h0000_3000; src_idx = 0;
    src_rand = 1; w_rand = 1;
    pulse_start(32'h0010_0000, 24'd40);
    wait_done("t3_done", 2000);
    check_job("t3", 32'h0010_0000, 40);
    src_rand = 0; w_rand = 0;

    // 4: empty job
    clear_logs();
    pulse_start(32'h0060_0000, 24'd0);
    chk("t4_done_hi", 32'(done), 1);
    chk("t4_busy_lo", 32'(busy), 0);
    @(posedge axi_aclk);
    #1;
    chk("t4_done_lo", 32'(done), 0);
    chk("t4_busy_lo2", 32'(busy), 0);
    repeat (5) @(posedge axi_aclk);
    #2;
    chk("t4_aw_cnt", aw_addr_q.size(), 0);
    chk("t4_done_cnt", done_cnt, 1);

    // 5: awready stalled, extra starts while busy
    clear_logs(); data_base = 32'h0000_5000; src_idx = 0;
    aw_hold = 1;
    pulse_start(32'h0020_0000, 24'd20);
    n = 0;
    while (!axi.awvalid && n < 100) begin
      @(posedge axi_aclk);
      #2;
      n++;
    end
    chk("t5_awvalid", 32'(axi.awvalid), 1);
    repeat (4) @(posedge axi_aclk);
    pulse_start(32'h0099_0000, 24'd5);
    repeat (4) @(posedge axi_aclk);
    #2;
    chk("t5_awaddr", axi.awaddr, 32'h0020_0000);
    chk("t5_awlen", 32'(axi.awlen), 15);
    chk("t5_busy", 32'(busy), 1);
    aw_hold = 0;
    wait_done("t5_done", 300);
    check_job("t5", 32'h0020_0000, 20);
    repeat (10) @(posedge axi_aclk);
    #2;
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_idle", 32'(busy), 0);

    // 6: reset during the second burst's data phase
    clear_logs(); data_base = 32'h0000_6000; src_idx = 0;
    pulse_start(32'h0030_0000, 24'd40);
    n = 0;
    while (w_cnt < 20 && n < 300) begin
      @(posedge axi_aclk);
      #2;
      n++;
    end
    chk("t6_mid_w2", 32'(w_cnt >= 20 && w_cnt < 32), 1);
    @(negedge axi_aclk);
    #2;
    axi_areset = 1'b1;
    #1;
    check_outputs_zero("t6_async");
    repeat (3) @(posedge axi_aclk);
    #2;
    chk("t6_no_done", done_cnt, 0);
    clear_logs(); data_base = 32'h0000_7000; src_idx = 0;
    @(posedge axi_aclk);
    #1;
    axi_areset = 1'b0;
    pulse_start(32'h0050_0000, 24'd18);
    wait_done("t6_done", 400);
    check_job("t6", 32'h0050_0000, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
